serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial adder built around a single 1-bit full-adder slice plus a carry flip-flop.
- Computes one operand bit pair per clock, LSB first, so an N-bit add reuses one adder slice over N cycles instead of a ripple chain.
- Sits upstream of result consumers that accept a parallel sum with a done pulse. Trades latency for area in area-constrained datapaths.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  request to begin an add; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- carry_in  input  1  initial carry; captured on the accepted start edge.
- ready  output  1  high only in IDLE; block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; sum/carry_out valid.
- sum  output  WIDTH  registered result, held until the next result is written.
- carry_out  output  1  registered final carry, held with sum.

Behaviour:
- Interface fixed: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0. Internal shift registers, carry register and bit counter are all 0.
- FSM states are IDLE, RUN and DONE. ready, busy and done decode directly from state.
- IDLE:
  - On an edge with start=1, load A_sh=a, B_sh=b, c_reg=carry_in, cnt=0, and go to RUN.
  - start=0 stays in IDLE.
- RUN, every edge:
  - Slice computes s = A_sh[0]^B_sh[0]^c_reg and co = majority(A_sh[0],B_sh[0],c_reg).
  - S_sh shifts right with s entering the MSB. A_sh and B_sh shift right with 0 fill. c_reg <= co.
  - cnt increments. cnt width is $clog2(WIDTH) bits.
  - On the edge where cnt==WIDTH-1 (last bit), write sum <= {s, S_sh[WIDTH-1:1]}, write carry_out <= co, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Accepted start at edge E0 gives RUN over edges E1..E_WIDTH.
  - done is high between E_WIDTH and E_WIDTH+1.
  - ready returns after E_WIDTH+1.
  - Throughput is one add per WIDTH+2 cycles when start is held high.
- start while in RUN or DONE is ignored: no restart, no operand recapture. a, b and carry_in may change freely after capture.
- sum and carry_out change only on the final RUN edge or on reset. They are stable and held through IDLE.
- Arithmetic: {carry_out,sum} = a + b + carry_in, exact modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-RUN or mid-DONE aborts the operation: no done pulse, sum and carry_out cleared to 0, ready=1 immediately (asynchronous).
- No X-propagation: every register has an explicit reset value.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x3C, carry_in=0 -> done exactly 8 edges after the accepted start; sum=0x96, carry_out=0; ready=1 one cycle after done.
- WIDTH=8, a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1. Then a=0xFF, b=0x00, carry_in=1 -> sum=0x00, carry_out=1. Then a=0x00, b=0x00, carry_in=0 -> sum=0x00, carry_out=0.
- Start accepted with a=0x10, b=0x20; on RUN cycle 3, pulse start with a=0xFF, b=0xFF and change operands -> result still sum=0x30, carry_out=0; no second done follows.
- Start with start held high continuously across two ops (0x01+0x02, then 0x80+0x80) -> done pulses 10 cycles apart. First result sum=0x03, carry_out=0; second result sum=0x00, carry_out=1.
- Assert rst during RUN cycle 4 -> ready=1, busy=0, sum=0, carry_out=0 immediately without a clock edge; no done. A later start with 0x07+0x09 -> sum=0x10.
- WIDTH=4, exhaustive over all a, b, carry_in (512 cases) -> {carry_out,sum} equals a+b+carry_in for every case; done width is always 1 cycle.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first.
// Latency: done pulses WIDTH edges after the accepted start; ready returns one cycle later.
// Backpressure: start is only sampled while ready=1; start in RUN/DONE is ignored.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the upper WIDTH-1 bits of the partial-sum shifter; the lowest
  // bit would fall off on the final shift, so it is never stored.
  logic [WIDTH-2:0] s_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             co_bit;
  logic [WIDTH-1:0] s_next;

  // The single adder slice working on the current LSB pair.
  assign s_bit  = a_sh[0] ^ b_sh[0] ^ c_reg;
  assign co_bit = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);
  // Partial sum after this edge's shift; on the last bit this is the full result.
  assign s_next = {s_bit, s_sh};

  // Status flags are pure decodes of the state register.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // Control FSM plus datapath shifters, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= carry_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next[WIDTH-1:1];
          c_reg <= co_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= s_next;
            carry_out <= co_bit;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
// Expected results come from plain integer addition; a monitor pops them on each done pulse.
// Latency, done width and ready-after-done are checked against the accept cycle.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ci8 = 1'b0;
  logic       ready8, busy8, done8, co8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ci4 = 1'b0;
  logic       ready4, busy4, done4, co4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] q8[$];
  int         acc8[$];
  logic [4:0] q4[$];
  int         acc4[$];
  logic       prev_done8 = 1'b0, prev_done4 = 1'b0;
  int         last_done_cyc8 = 0, prev_done_cyc8 = 0;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .carry_in(ci4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done8) begin
        chk("done8_width", {31'd0, done8}, 32'd0);
        chk("ready8_after_done", {31'd0, ready8}, 32'd1);
      end
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          int         ac;
          e  = q8.pop_front();
          ac = acc8.pop_front();
          chk("sum8", {23'd0, co8, sum8}, {23'd0, e});
          chk("latency8", cyc - ac, 32'd8);
        end
        prev_done_cyc8 = last_done_cyc8;
        last_done_cyc8 = cyc;
      end
      prev_done8 = done8;
    end else begin
      prev_done8 = 1'b0;
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done4) begin
        chk("done4_width", {31'd0, done4}, 32'd0);
        chk("ready4_after_done", {31'd0, ready4}, 32'd1);
      end
      if (done4) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 32'd1, 32'd0);
        end else begin
          logic [4:0] e;
          int         ac;
          e  = q4.pop_front();
          ac = acc4.pop_front();
          chk("sum4", {27'd0, co4, sum4}, {27'd0, e});
          chk("latency4", cyc - ac, 32'd4);
        end
      end
      prev_done4 = done4;
    end else begin
      prev_done4 = 1'b0;
    end
  end

  // Wait for ready, present an op, push the reference result on the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready8 && n < 100);
    if (!ready8) begin
      chk("timeout_ready8", 32'd1, 32'd0);
    end else begin
      start8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
      @(posedge clk);
      #1;
      q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
      acc8.push_back(cyc);
      if (!hold) start8 = 1'b0;
    end
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready4 && n < 100);
    if (!ready4) begin
      chk("timeout_ready4", 32'd1, 32'd0);
    end else begin
      start4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
      @(posedge clk);
      #1;
      q4.push_back({1'b0, a} + {1'b0, b} + {4'd0, ci});
      acc4.push_back(cyc);
      start4 = 1'b0;
    end
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || !ready8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) chk("timeout_drain8", 32'd1, 32'd0);
  endtask

  task automatic drain4();
    int n = 0;
    while ((q4.size() != 0 || !ready4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) chk("timeout_drain4", 32'd1, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, ready8}, 32'd1);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_co", {31'd0, co8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic and carry-edge operations.
    issue8(8'h5A, 8'h3C, 1'b0, 0);
    drain8();
    issue8(8'hFF, 8'h01, 1'b0, 0);
    issue8(8'hFF, 8'h00, 1'b1, 0);
    issue8(8'h00, 8'h00, 1'b0, 0);
    drain8();

    // start pulsed mid-RUN with new operands must be ignored.
    issue8(8'h10, 8'h20, 1'b0, 0);
    @(posedge clk); @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain8();
    repeat (12) @(negedge clk);

    // Asynchronous reset during RUN aborts the op and clears outputs.
    issue8(8'h55, 8'h66, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, ready8}, 32'd1);
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_done", {31'd0, done8}, 32'd0);
    chk("arst_sum", {24'd0, sum8}, 32'd0);
    chk("arst_co", {31'd0, co8}, 32'd0);
    q8.delete();
    acc8.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'h07, 8'h09, 1'b0, 0);
    drain8();

    // start held high across two ops: done pulses WIDTH+2 apart.
    issue8(8'h01, 8'h02, 1'b0, 1);
    issue8(8'h80, 8'h80, 1'b0, 1);
    start8 = 1'b0;
    drain8();
    chk("held_done_spacing", last_done_cyc8 - prev_done_cyc8, 32'd10);

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 0);
    end
    drain8();

    // Exhaustive WIDTH=4.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      issue4(v[3:0], v[7:4], v[8]);
    end
    drain4();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
